sum_splitter: RTL and testbench

SUM_SPLITTER -- requirements
Module: sum_splitter

---
 rtl/sum_splitter_pkg.sv | 13 +
 rtl/sum_splitter_if.sv | 34 +++
 rtl/sum_splitter_chunk_calc.sv | 19 +
 rtl/sum_splitter.sv | 74 +++++++
 tb/tb_sum_splitter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/sum_splitter_pkg.sv
// rtl/sum_splitter_pkg.sv - shared widths, saturation marker and FSM encoding for sum_splitter
package sum_split_pkg;

  localparam int SUM_W   = 16;
  localparam int CHUNK_W = 8;
  localparam logic [SUM_W-1:0] SAT_MARK = 16'hFFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/sum_splitter_if.sv
// rtl/sum_splitter_if.sv - load/output handshake bundle; beat_cnt present under SUM_SPLITTER_BEAT_CNT_EN
interface sum_splitter_if;
  import sum_split_pkg::*;

  logic               load_valid;
  logic               load_ready;
  logic [SUM_W-1:0]   total;
  logic               out_valid;
  logic               out_ready;
  logic [CHUNK_W-1:0] out_data;
  logic               out_last;
  logic               sat;
`ifdef SUM_SPLITTER_BEAT_CNT_EN
  logic [SUM_W-1:0]   beat_cnt;

  modport master (
    output load_valid, total, out_ready,
    input  load_ready, out_valid, out_data, out_last, sat, beat_cnt
  );
  modport slave (
    input  load_valid, total, out_ready,
    output load_ready, out_valid, out_data, out_last, sat, beat_cnt
  );
`else
  modport master (
    output load_valid, total, out_ready,
    input  load_ready, out_valid, out_data, out_last, sat
  );
  modport slave (
    input  load_valid, total, out_ready,
    output load_ready, out_valid, out_data, out_last, sat
  );
`endif
endinterface

// File: rtl/sum_splitter_chunk_calc.sv
// rtl/sum_splitter_chunk_calc.sv - combinational min(residual, MAX_CHUNK) and final-chunk flag
module split_chunk_calc
  import sum_split_pkg::*;
#(
  parameter int MAX_CHUNK = 255
) (
  input  logic [SUM_W-1:0]   residual,
  output logic [CHUNK_W-1:0] chunk_data,
  output logic               chunk_last
);

  localparam logic [SUM_W-1:0]   MAX_WIDE   = SUM_W'(MAX_CHUNK);
  localparam logic [CHUNK_W-1:0] MAX_NARROW = CHUNK_W'(MAX_CHUNK);

  // When the residual fits in one chunk its upper byte is zero, so truncation is exact.
  assign chunk_last = (residual <= MAX_WIDE);
  assign chunk_data = chunk_last ? residual[CHUNK_W-1:0] : MAX_NARROW;

endmodule

// File: rtl/sum_splitter.sv
// rtl/sum_splitter.sv - splits a 16-bit total into chunks of at most MAX_CHUNK; optional SUM_SPLITTER_BEAT_CNT_EN beat counter
module sum_splitter
  import sum_split_pkg::*;
#(
  parameter int MAX_CHUNK = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  sum_splitter_if.slave bus
);

  state_t             state;
  logic [SUM_W-1:0]   residual;
  logic               sat_q;
  logic [CHUNK_W-1:0] chunk_data;
  logic               chunk_last;

  split_chunk_calc #(
    .MAX_CHUNK (MAX_CHUNK)
  ) u_chunk_calc (
    .residual   (residual),
    .chunk_data (chunk_data),
    .chunk_last (chunk_last)
  );

  // Chunk never exceeds the residual, so this subtraction cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      residual <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            residual <= bus.total;
            sat_q    <= (bus.total == SAT_MARK);
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            residual <= residual - {{(SUM_W-CHUNK_W){1'b0}}, chunk_data};
            if (chunk_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.out_valid  = (state == DRAIN);
  assign bus.out_data   = (state == DRAIN) ? chunk_data : '0;
  assign bus.out_last   = (state == DRAIN) && chunk_last;
  assign bus.sat        = sat_q;

`ifdef SUM_SPLITTER_BEAT_CNT_EN
  logic [SUM_W-1:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (state == IDLE && bus.load_valid) begin
      beat_cnt_q <= '0;
    end else if (state == DRAIN && bus.out_ready) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign bus.beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_sum_splitter.sv
// tb/tb_sum_splitter.sv - directed self-checking bench for sum_splitter (MAX_CHUNK 255 and 1 instances)
module tb_sum_splitter;

  logic clk;
  logic rst_n;
  logic sel_b;
  int   total_cnt;
  int   bad_cnt;

  sum_splitter_if bus_a ();
  sum_splitter_if bus_b ();

  sum_splitter #(.MAX_CHUNK(255)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  sum_splitter #(.MAX_CHUNK(1))   dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic       ov, ol, lr, st;
  logic [7:0] od;
  assign ov = sel_b ? bus_b.out_valid  : bus_a.out_valid;
  assign ol = sel_b ? bus_b.out_last   : bus_a.out_last;
  assign lr = sel_b ? bus_b.load_ready : bus_a.load_ready;
  assign od = sel_b ? bus_b.out_data   : bus_a.out_data;
  assign st = sel_b ? bus_b.sat        : bus_a.sat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_load(input bit v, input logic [15:0] t);
    if (sel_b) begin bus_b.load_valid = v; bus_b.total = t; end
    else       begin bus_a.load_valid = v; bus_a.total = t; end
  endtask

  task automatic do_load(input logic [15:0] t);
    @(negedge clk);
    set_load(1'b1, t);
    @(posedge clk);
    #1;
    set_load(1'b0, 16'd0);
    check("latency1_valid", ov, 1);
  endtask

  // Drains with out_ready=1; n beats, all 'full' except the final 'lastv'.
  // A load is offered during the last beat and must be ignored.
  task automatic drain(input string tag, input int full, input int lastv, input int n, input int tot);
    int beats = 0;
    int sum = 0;
    bit done = 0;
    for (int c = 0; c < n + 8 && !done; c++) begin
      @(negedge clk);
      if (!ov) begin
        check({tag, "_early_idle"}, ov, 1);
        done = 1;
      end else begin
        beats++;
        sum += od;
        check({tag, "_data"}, od, (beats == n) ? lastv : full);
        check({tag, "_last"}, ol, (beats == n) ? 1 : 0);
        if (ol || beats >= n) begin
          done = 1;
          set_load(1'b1, 16'd5);
        end
      end
    end
    check({tag, "_beats"}, beats, n);
    check({tag, "_sum"}, sum, tot);
    @(negedge clk);
    check({tag, "_idle_valid"}, ov, 0);
    check({tag, "_idle_ready"}, lr, 1);
    set_load(1'b0, 16'd0);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    sel_b     = 1'b0;
    bus_a.load_valid = 1'b0; bus_a.total = '0; bus_a.out_ready = 1'b1;
    bus_b.load_valid = 1'b0; bus_b.total = '0; bus_b.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check("rst_load_ready", lr, 1);
    check("rst_out_valid", ov, 0);
    check("rst_out_data", od, 0);
    check("rst_out_last", ol, 0);
    check("rst_sat", st, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_load(16'd600);
    check("t600_sat", st, 0);
    drain("t600", 255, 90, 3, 600);

    do_load(16'd0);
    drain("t0", 0, 0, 1, 0);

    // stall: ready low across three edges, data must hold
    bus_a.out_ready = 1'b0;
    do_load(16'd300);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_data", od, 255);
      check("stall_last", ol, 0);
      check("stall_valid", ov, 1);
    end
    bus_a.out_ready = 1'b1;
    drain("t300", 45, 45, 1, 45);

    do_load(16'hFFFF);
    check("tffff_sat", st, 1);
    drain("tffff", 255, 255, 257, 65535);
    check("tffff_sat_hold", st, 1);
`ifdef SUM_SPLITTER_BEAT_CNT_EN
    check("tffff_beat_cnt", bus_a.beat_cnt, 257);
`endif

    // reset mid-drain
    do_load(16'd1000);
    check("t1000_sat", st, 0);
    @(negedge clk); check("t1000_b1", od, 255);
    @(negedge clk); check("t1000_b2", od, 255);
    @(negedge clk); check("t1000_b3_valid", ov, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", ov, 0);
    check("async_rst_ready", lr, 1);
    check("async_rst_data", od, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", ov, 0);
      check("post_rst_ready", lr, 1);
      check("post_rst_sat", st, 0);
    end

    // sat cleared by reset
    do_load(16'hFFFF);
    @(negedge clk);
    check("sat_before_rst", st, 1);
    rst_n = 1'b0;
    #1;
    check("sat_after_rst", st, 0);
    @(negedge clk);
    rst_n = 1'b1;

    sel_b = 1'b1;
    do_load(16'd3);
    drain("mc1_t3", 1, 1, 3, 3);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
